// File: rtl/execution_block.sv
// execution_block: single-issue ALU stage with a 16-cycle shift-add multiplier
module execution_block (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  op_ex,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] st_data,
  input  logic        mem_rw_rr,
  input  logic        mem_en_rr,
  input  logic        mem_mux_sel_rr,
  output logic [15:0] ans_ex,
  output logic [15:0] DM_data,
  output logic        mem_rw_ex,
  output logic        mem_en_ex,
  output logic        mem_mux_sel_dm,
  output logic [3:0]  flags_ex,
  output logic        valid_ex,
  output logic        stall_ex
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t      state_q;
  logic [15:0] ans_q, dm_q, acc_q, a_q, b_q, st_q;
  logic [3:0]  flags_q, cnt_q;
  logic        valid_q, en_q, rw_q, sel_q, en_c_q, rw_c_q, sel_c_q;
  logic [16:0] sum, dif;
  logic [15:0] res_d, mac_d;
  logic [1:0]  cv_d;
  logic [3:0]  flags_d;
  // Single-cycle ALU result, flags and the next multiplier partial sum
  always_comb begin
    sum = {1'b0, A} + {1'b0, B};
    dif = {1'b0, A} - {1'b0, B};
    res_d = 16'h0000;
    case (op_ex)
      4'd0: res_d = sum[15:0];
      4'd1: res_d = dif[15:0];
      4'd2: res_d = A & B;
      4'd3: res_d = A | B;
      4'd4: res_d = A ^ B;
      4'd5: res_d = ~A;
      4'd6: res_d = A << B[3:0];
      4'd7: res_d = A >> B[3:0];
      4'd8: res_d = $signed(A) >>> B[3:0];
      4'd9: res_d = B;
      default: res_d = 16'h0000;
    endcase
    cv_d = op_ex == 4'd0 ? {sum[16], (A[15] == B[15]) && (sum[15] != A[15])} :
           op_ex == 4'd1 ? {~dif[16], (A[15] != B[15]) && (dif[15] != A[15])} : 2'b00;
    flags_d = op_ex > 4'd10 ? flags_q : {res_d == 16'h0000, res_d[15], cv_d};
    mac_d = acc_q + (b_q[0] ? a_q : 16'h0000);
  end
  // IDLE/MUL control with registered outputs; MUL adds one shifted partial product per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ans_q   <= 16'h0000;
      dm_q    <= 16'h0000;
      flags_q <= 4'h0;
      valid_q <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= 4'h0;
    end else if (state_q == IDLE) begin
      if (valid_in && op_ex == 4'd10) begin
        state_q <= MUL;
        cnt_q   <= 4'h0;
        acc_q   <= 16'h0000;
        a_q     <= A;
        b_q     <= B;
        st_q    <= st_data;
        en_c_q  <= mem_en_rr;
        rw_c_q  <= mem_rw_rr;
        sel_c_q <= mem_mux_sel_rr;
        valid_q <= 1'b0;
        en_q    <= 1'b0;
        rw_q    <= 1'b0;
      end else if (valid_in) begin
        ans_q   <= res_d;
        dm_q    <= st_data;
        flags_q <= flags_d;
        en_q    <= mem_en_rr;
        rw_q    <= mem_rw_rr;
        sel_q   <= mem_mux_sel_rr;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
        en_q    <= 1'b0;
        rw_q    <= 1'b0;
      end
    end else begin
      acc_q <= mac_d;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 4'h1;
      if (cnt_q == 4'hF) begin
        state_q <= IDLE;
        ans_q   <= mac_d;
        dm_q    <= st_q;
        flags_q <= {mac_d == 16'h0000, mac_d[15], 2'b00};
        en_q    <= en_c_q;
        rw_q    <= rw_c_q;
        sel_q   <= sel_c_q;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
        en_q    <= 1'b0;
        rw_q    <= 1'b0;
      end
    end
  end
  assign ans_ex         = ans_q;
  assign DM_data        = dm_q;
  assign flags_ex       = flags_q;
  assign valid_ex       = valid_q;
  assign mem_en_ex      = en_q;
  assign mem_rw_ex      = rw_q;
  assign mem_mux_sel_dm = sel_q;
  assign stall_ex       = state_q == MUL;
endmodule

// File: tb/tb_execution_block.sv
// tb_execution_block: randomized and directed checks against an arithmetic reference model
module tb_execution_block;
  logic        clk = 1'b0, reset, valid_in, mem_rw_rr, mem_en_rr, mem_mux_sel_rr;
  logic [3:0]  op_ex;
  logic [15:0] A, B, st_data;
  logic [15:0] ans_ex, DM_data;
  logic        mem_rw_ex, mem_en_ex, mem_mux_sel_dm, valid_ex, stall_ex;
  logic [3:0]  flags_ex;
  int errors = 0, checks = 0;
  logic [15:0] m_ans, m_dm;
  logic [3:0]  m_flags;
  logic        m_valid, m_en, m_rw, m_sel;

  execution_block dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op_ex(op_ex), .A(A), .B(B),
    .st_data(st_data), .mem_rw_rr(mem_rw_rr), .mem_en_rr(mem_en_rr),
    .mem_mux_sel_rr(mem_mux_sel_rr), .ans_ex(ans_ex), .DM_data(DM_data),
    .mem_rw_ex(mem_rw_ex), .mem_en_ex(mem_en_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .flags_ex(flags_ex), .valid_ex(valid_ex), .stall_ex(stall_ex)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a, b, s,
                       input logic en, rw, sel);
    valid_in = v; op_ex = op; A = a; B = b; st_data = s;
    mem_en_rr = en; mem_rw_rr = rw; mem_mux_sel_rr = sel;
  endtask

  // Reference: results straight from the operation definitions using wide integers
  function automatic void model_exec(input logic [3:0] op, input logic [15:0] a, b, s,
                                     input logic en, rw, sel);
    longint ua, ub, sa, sb, r;
    logic [15:0] ans;
    logic c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin r = ua + ub; ans = r[15:0]; c = r > 65535; v = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd1: begin r = ua - ub; ans = r[15:0]; c = ua >= ub; v = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd2: ans = a & b;
      4'd3: ans = a | b;
      4'd4: ans = a ^ b;
      4'd5: ans = ~a;
      4'd6: begin r = ua * (longint'(1) << b[3:0]); ans = r[15:0]; end
      4'd7: begin r = ua / (longint'(1) << b[3:0]); ans = r[15:0]; end
      4'd8: begin r = sa >>> b[3:0]; ans = r[15:0]; end
      4'd9: ans = b;
      4'd10: begin r = ua * ub; ans = r[15:0]; end
      default: ans = 16'h0000;
    endcase
    m_ans = ans;
    if (op <= 4'd10) m_flags = {ans == 16'h0000, ans[15], c, v};
    m_dm = s; m_en = en; m_rw = rw; m_sel = sel; m_valid = 1'b1;
  endfunction

  function automatic void model_bubble;
    m_valid = 1'b0; m_en = 1'b0; m_rw = 1'b0;
  endfunction

  function automatic void model_reset;
    m_ans = '0; m_dm = '0; m_flags = '0; m_valid = 0; m_en = 0; m_rw = 0; m_sel = 0;
  endfunction

  function automatic logic [39:0] obs;
    return {ans_ex, flags_ex, DM_data, valid_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_dm};
  endfunction

  function automatic logic [39:0] expv;
    return {m_ans, m_flags, m_dm, m_valid, m_en, m_rw, m_sel};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    drive(1, 4'd10, 16'h1234, 16'h5678, 16'h9ABC, 1, 1, 1);
    step; step;
    reset = 1'b0;
    drive(0, 4'd0, 0, 0, 0, 0, 0, 0);
    model_reset;
    checks++;
    if (obs() !== 40'h0 || stall_ex !== 1'b0) begin
      errors++;
      $display("FAIL reset: outputs=%h stall=%b, required 0 and 0", obs(), stall_ex);
    end
  endtask

  task automatic test_add_overflow;
    drive(1, 4'd0, 16'h7FFF, 16'h0001, 16'h0000, 0, 0, 0);
    step;
    model_exec(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 0, 0, 0);
    checks++;
    if (ans_ex !== 16'h8000 || flags_ex !== 4'b0101 || valid_ex !== 1'b1) begin
      errors++;
      $display("FAIL add_overflow: ans=%h flags=%b valid=%b, required 8000 0101 1", ans_ex, flags_ex, valid_ex);
    end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL add_overflow_model: got %h, required %h", obs(), expv());
    end
  endtask

  task automatic test_sub_mem;
    drive(1, 4'd1, 16'h0003, 16'h0003, 16'hFFFF, 1, 1, 0);
    step;
    model_exec(4'd1, 16'h0003, 16'h0003, 16'hFFFF, 1, 1, 0);
    checks++;
    if (ans_ex !== 16'h0000 || flags_ex[3] !== 1'b1 || flags_ex[1] !== 1'b1 || mem_en_ex !== 1'b1 ||
        mem_rw_ex !== 1'b1 || DM_data !== 16'hFFFF) begin
      errors++;
      $display("FAIL sub_mem: ans=%h flags=%b en=%b rw=%b dm=%h, required 0000 Z=1 C=1 1 1 FFFF",
               ans_ex, flags_ex, mem_en_ex, mem_rw_ex, DM_data);
    end
  endtask

  task automatic test_mul;
    drive(1, 4'd10, 16'h0012, 16'h0034, 16'hBEEF, 1, 0, 1);
    step;
    model_bubble;
    checks++;
    if (stall_ex !== 1'b1) begin
      errors++;
      $display("FAIL mul_stall_start: stall=%b, required 1", stall_ex);
    end
    drive(1, 4'd0, 16'h0005, 16'h0006, 16'h1111, 1, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      step;
      checks++;
      if (obs() !== expv() || stall_ex !== 1'b1) begin
        errors++;
        $display("FAIL mul_bubble edge %0d: got %h stall=%b, required %h stall=1", k, obs(), stall_ex, expv());
      end
    end
    step;
    model_exec(4'd10, 16'h0012, 16'h0034, 16'hBEEF, 1, 0, 1);
    checks++;
    if (ans_ex !== 16'h03A8 || valid_ex !== 1'b1 || stall_ex !== 1'b0 || obs() !== expv()) begin
      errors++;
      $display("FAIL mul_result: ans=%h valid=%b stall=%b got %h, required 03A8 1 0 %h",
               ans_ex, valid_ex, stall_ex, obs(), expv());
    end
    step;
    model_exec(4'd0, 16'h0005, 16'h0006, 16'h1111, 1, 1, 0);
    checks++;
    if (ans_ex !== 16'h000B || obs() !== expv()) begin
      errors++;
      $display("FAIL mul_next_add: got %h, required %h", obs(), expv());
    end
  endtask

  task automatic test_sar;
    drive(1, 4'd8, 16'h8000, 16'h0004, 16'h0042, 0, 0, 1);
    step;
    model_exec(4'd8, 16'h8000, 16'h0004, 16'h0042, 0, 0, 1);
    checks++;
    if (ans_ex !== 16'hF800 || flags_ex[2] !== 1'b1 || obs() !== expv()) begin
      errors++;
      $display("FAIL sar: ans=%h flags=%b, required F800 N=1", ans_ex, flags_ex);
    end
  endtask

  task automatic test_reset_mid_mul;
    drive(1, 4'd10, 16'h00FF, 16'h0101, 16'h7777, 1, 1, 1);
    step;
    drive(0, 4'd0, 0, 0, 0, 0, 0, 0);
    repeat (4) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    model_reset;
    checks++;
    if (obs() !== 40'h0 || stall_ex !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul: outputs=%h stall=%b, required 0 and 0", obs(), stall_ex);
    end
    for (int k = 0; k < 16; k++) begin
      step;
      checks++;
      if (valid_ex !== 1'b0 || stall_ex !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_mul_no_result cycle %0d: valid=%b stall=%b, required 0 0", k, valid_ex, stall_ex);
      end
    end
  endtask

  task automatic test_bubble;
    drive(1, 4'd0, 16'h1234, 16'h1111, 16'hCAFE, 1, 1, 1);
    step;
    model_exec(4'd0, 16'h1234, 16'h1111, 16'hCAFE, 1, 1, 1);
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL bubble_add: got %h, required %h", obs(), expv());
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, 1, 0);
      step;
      model_bubble;
      checks++;
      if (obs() !== expv() || ans_ex !== 16'h2345) begin
        errors++;
        $display("FAIL bubble idle %0d: got %h, required %h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_random;
    logic v, en, rw, sel;
    logic [3:0] op;
    logic [15:0] a, b, s;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom % 4) != 0;
      op = ($urandom % 5 == 0) ? 4'd10 : 4'($urandom);
      a = 16'($urandom); b = 16'($urandom); s = 16'($urandom);
      en = 1'($urandom); rw = 1'($urandom); sel = 1'($urandom);
      drive(v, op, a, b, s, en, rw, sel);
      step;
      if (v && op == 4'd10) begin
        model_bubble;
        checks++;
        if (stall_ex !== 1'b1) begin
          errors++;
          $display("FAIL rand_mul_stall iter %0d: stall=%b, required 1", i, stall_ex);
        end
        for (int k = 1; k <= 15; k++) begin
          drive(1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, 1, 1);
          step;
          checks++;
          if (obs() !== expv() || stall_ex !== 1'b1) begin
            errors++;
            $display("FAIL rand_mul_bubble iter %0d edge %0d: got %h stall=%b, required %h", i, k, obs(), stall_ex, expv());
          end
        end
        drive(0, 4'd0, 0, 0, 0, 0, 0, 0);
        step;
        model_exec(4'd10, a, b, s, en, rw, sel);
      end else if (v) model_exec(op, a, b, s, en, rw, sel);
      else model_bubble;
      checks++;
      if (obs() !== expv() || stall_ex !== 1'b0) begin
        errors++;
        $display("FAIL rand iter %0d op=%0d v=%b a=%h b=%h: got %h stall=%b, required %h",
                 i, op, v, a, b, obs(), stall_ex, expv());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 4'd0, 0, 0, 0, 0, 0, 0);
    test_reset;
    test_add_overflow;
    test_sub_mem;
    test_mul;
    test_sar;
    test_reset_mid_mul;
    test_bubble;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execution_block.md
EXECUTION_BLOCK -- requirements
Module: execution_block

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high; sampled on the rising edge of clk.
REQ-003 SHALL have port valid_in, input, 1 bit: upstream presents an instruction this cycle.
REQ-004 SHALL have port op_ex, input, 4 bits: operation code.
REQ-005 SHALL have port A, input, 16 bits: operand A.
REQ-006 SHALL have port B, input, 16 bits: operand B.
REQ-007 SHALL have port st_data, input, 16 bits: store data for the memory stage.
REQ-008 SHALL have ports mem_rw_rr, mem_en_rr and mem_mux_sel_rr, input, 1 bit each: memory controls to be carried forward.
REQ-009 SHALL have port ans_ex, output, 16 bits: ALU result, used as the data-memory address or write-back value.
REQ-010 SHALL have port DM_data, output, 16 bits: registered st_data.
REQ-011 SHALL have ports mem_rw_ex, mem_en_ex and mem_mux_sel_dm, output, 1 bit each: registered memory controls.
REQ-012 SHALL have port flags_ex, output, 4 bits: {Z,N,C,V}.
REQ-013 SHALL have port valid_ex, output, 1 bit: the output register holds a new instruction.
REQ-014 SHALL have port stall_ex, output, 1 bit: combinational; high means upstream must hold its instruction and valid_in.

Function
REQ-015 SHALL accept an instruction when valid_in=1, state=IDLE and reset=0.
REQ-016 SHALL implement the following 16-bit operations, indexed by op_ex:
- 0 ADD: ans=A+B, C=carry out, V=signed overflow.
- 1 SUB: ans=A-B, C=no-borrow (A>=B unsigned), V=signed overflow.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 NOT A.
- 6 SHL: A<<B[3:0].
- 7 SHR: logical A>>B[3:0].
- 8 SAR: arithmetic A>>>B[3:0].
- 9 MOVB: ans=B.
- 10 MUL.
- 11-15: ans=16'h0000.
REQ-017 SHALL register results with 1-cycle latency for non-MUL ops: on the accept edge, load ans_ex, DM_data, all three memory controls and flags_ex, and set valid_ex=1.
REQ-018 SHALL compute Z=(ans==0) and N=ans[15] for every op; C=V=0 for ops 2-10; for ops 11-15 flags_ex SHALL hold its previous value.
REQ-019 SHALL implement MUL as a shift-add over 16 cycles producing the low 16 bits of A*B.
REQ-020 SHALL use the FSM states IDLE and MUL.
REQ-021 SHALL transition IDLE->MUL on the accept edge when op_ex=10, capturing A, B, st_data and all controls internally and clearing the 4-bit counter cnt.
REQ-022 SHALL hold stall_ex=1 while state=MUL; stall_ex=0 in IDLE.
REQ-023 SHALL present a bubble on every edge spent in MUL except the last: valid_ex=0, mem_en_ex=0, mem_rw_ex=0, ans_ex and flags_ex held.
REQ-024 SHALL, on the edge at which cnt=15, load ans_ex=product[15:0] and the captured controls and DM_data, set valid_ex=1, and return to IDLE; total latency from accept to valid_ex is 16 cycles.
REQ-025 SHALL ignore valid_in while in MUL, and SHALL accept a new instruction on the first IDLE cycle after MUL completes.
REQ-026 SHALL insert a bubble when in IDLE with valid_in=0: valid_ex=0, mem_en_ex=0, mem_rw_ex=0, with ans_ex, DM_data and flags_ex held.
REQ-027 SHALL discard the product bits above 15 on MUL overflow; flags_ex SHALL follow REQ-018.

Reset
REQ-028 SHALL, on any edge with reset=1, clear ans_ex, DM_data, flags_ex, valid_ex, mem_rw_ex, mem_en_ex, mem_mux_sel_dm and cnt, and set state=IDLE.
REQ-029 SHALL give reset priority over valid_in; reset during MUL SHALL abort the multiply with no result emitted, and stall_ex SHALL be 0 on the following cycle.

Verification
REQ-030 SHALL be verified by a bench covering the following scenarios:
- ADD A=16'h7FFF, B=16'h0001 -> next edge ans_ex=16'h8000, flags_ex={0,1,0,1}, valid_ex=1.
- SUB A=B=16'h0003, with mem_en_rr=1, mem_rw_rr=1 and st_data=16'hFFFF -> ans_ex=16'h0000, Z=1, C=1, mem_en_ex=1, mem_rw_ex=1, DM_data=16'hFFFF.
- MUL A=16'h0012, B=16'h0034 -> stall_ex=1 for 16 cycles with valid_ex=0 on edges 1-15, then ans_ex=16'h03A8 with valid_ex=1; an ADD held on valid_in is accepted on the next edge.
- SAR A=16'h8000, B=16'h0004 -> ans_ex=16'hF800, N=1.
- reset=1 asserted at cycle 5 of a MUL -> all outputs 0, stall_ex=0, no result emitted.
- valid_in=0 for 3 cycles after an ADD -> valid_ex=0 and mem_en_ex=0, with ans_ex unchanged.
